wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have one clock, `clk`; reset `rst` is synchronous and active-high.
REQ-002 SHALL use these ports (name, direction, width, meaning), clock and reset first:
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous active-high reset.
- `in_valid` in 1: upstream (MEM) instruction valid.
- `in_rd` in 5: destination register.
- `in_rf_we` in 1: instruction writes rd.
- `in_wb_sel` in 2: 00 ALU, 01 LOAD, 10 PC4, 11 IMM.
- `in_alu` in 32; `in_pc4` in 32; `in_imm` in 32.
- `in_load_data` in 32: raw memory word.
- `in_load_type` in 3: funct3; LB=000, LH=001, LW=010, LBU=100, LHU=101.
- `in_addr_lo` in 2: load address bits [1:0].
- `stall` in 1: hold stage contents.
- `flush` in 1: kill stage contents.
- `w_addr` out 5; `wen` out 1; `w_data` out 32: register-file write port.
- `misalign_err` out 1: one-cycle pulse on a misaligned load.
- `retire_cnt` out 32: retired-instruction counter.

Function
REQ-003 SHALL hold one stage register: valid, done, rd, rf_we, wb_sel, the four data operands, load_type and addr_lo.
REQ-004 Stage register update priority at each edge: rst, then flush, then stall, then normal load.
- flush: clear valid and done.
- stall: hold all fields.
- Otherwise: capture the in_* fields, set valid=in_valid and done=0.
REQ-005 A flush in the same cycle as a stall SHALL win.
REQ-006 Latency: an instruction sampled at edge N SHALL drive wen/w_data during cycle N..N+1, so the register file writes it at edge N+1.
REQ-007 `wen` SHALL equal valid & !done & rf_we & (rd != 0) & !misalign, all from registered state.
REQ-008 While stalled, done SHALL be set at the edge after the first write cycle, so each instruction is written and retired exactly once.
REQ-009 `w_addr` SHALL equal the registered rd.
REQ-010 `w_data` SHALL be selected by wb_sel as ALU, extended load, PC4 or IMM.
REQ-011 Load extension:
- LB/LBU: select byte addr_lo, then sign- or zero-extend.
- LH/LHU: select halfword addr_lo[1], then sign- or zero-extend.
- LW: full word.
- Any other funct3: data 0, no error.
REQ-012 Misalignment SHALL be detected for LH/LHU with addr_lo[0]=1 and for LW with addr_lo!=0, only when wb_sel=LOAD.
REQ-013 A misaligned load SHALL suppress wen and pulse `misalign_err` for exactly one cycle, suppressed once done=1.
REQ-014 `retire_cnt` SHALL increment by 1 in each cycle where valid & !done, whether or not it writes, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-015 A flush asserted while an entry is valid SHALL NOT cancel that cycle's write; it only clears the stage at the next edge.

Reset
REQ-016 On rst at a clock edge SHALL clear valid, done, every stage field and `retire_cnt`.
REQ-017 After reset, `wen`=0, `w_addr`=0, `w_data`=0, `misalign_err`=0 and `retire_cnt`=0.
REQ-018 A reset mid-stall SHALL discard the held instruction with no write.

Configuration
REQ-019 With macro `WB_FWD_EN` defined, the module SHALL add:
- Inputs `fwd_rs1` and `fwd_rs2` (5 bits each).
- Outputs `fwd_rs1_hit`, `fwd_rs2_hit` (1 bit each) and `fwd_data` (32 bits).
- Behaviour: hit = wen & (rd == rs), combinational; fwd_data = w_data.
REQ-020 Without `WB_FWD_EN`, these ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-021 Package `wb_pkg` SHALL hold the wb_sel encodings, the load funct3 encodings and a width constant XLEN=32.
REQ-022 Load selection/extension and misalignment detection SHALL be a combinational sub-module `load_ext`.

Verification
REQ-023 The bench SHALL cover these scenarios (stimulus -> required response):
- ALU write: rd=5, wb_sel=ALU, alu=0x12345678, valid=1 -> next cycle wen=1, w_addr=5, w_data=0x12345678, retire_cnt=1.
- LB: load_data=0x80FF7F01, addr_lo=3, LB -> w_data=0xFFFFFF80; same with LBU -> 0x00000080; LH with addr_lo=2 -> 0xFFFF80FF.
- x0 and misalignment: rd=0 ALU write -> wen=0, retire_cnt still increments; LW with addr_lo=2 -> wen=0, misalign_err high for exactly 1 cycle.
- Stall: stall held 3 cycles on a valid entry -> wen high for 1 cycle only, retire_cnt +1; stall+flush together -> stage empty next cycle.
- Counter wrap: force retire_cnt to 0xFFFFFFFF, retire one instruction -> 0; rst mid-stall -> no write, all outputs 0.
- With `WB_FWD_EN`: writing rd=7 with fwd_rs1=7, fwd_rs2=0 -> fwd_rs1_hit=1, fwd_rs2_hit=0, fwd_data=w_data.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: operand width, write-back
// source select encodings, load funct3 encodings and the stage register layout.
package wb_pkg;

  localparam int XLEN = 32;

  // Source of the value written back to the register file.
  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_IMM  = 2'b11
  } wb_sel_e;

  // Load funct3 encodings; any other value is treated as "no data".
  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  // Everything the stage holds for one instruction.
  typedef struct packed {
    logic            valid;
    logic            done;
    logic [4:0]      rd;
    logic            rf_we;
    wb_sel_e         wb_sel;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] load_data;
    logic [2:0]      load_type;
    logic [1:0]      addr_lo;
  } stage_t;

endpackage

// File: rtl/load_ext.sv
// Combinational load formatter: picks the addressed byte/halfword out of the
// raw memory word, sign- or zero-extends it, and flags misaligned accesses.
module load_ext import wb_pkg::*; (
  input  logic [XLEN-1:0] load_data_i,
  input  logic [2:0]      load_type_i,
  input  logic [1:0]      addr_lo_i,
  input  logic            is_load_i,
  output logic [XLEN-1:0] data_o,
  output logic            misalign_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Lane selection followed by extension according to funct3; unknown
  // funct3 values produce zero rather than an error.
  always_comb begin
    byteSel = 8'h00;
    case (addr_lo_i)
      2'd0: byteSel = load_data_i[7:0];
      2'd1: byteSel = load_data_i[15:8];
      2'd2: byteSel = load_data_i[23:16];
      2'd3: byteSel = load_data_i[31:24];
      default: byteSel = 8'h00;
    endcase
    halfSel = addr_lo_i[1] ? load_data_i[31:16] : load_data_i[15:0];

    data_o = '0;
    case (load_type_i)
      LD_LB:   data_o = {{24{byteSel[7]}}, byteSel};
      LD_LBU:  data_o = {24'h000000, byteSel};
      LD_LH:   data_o = {{16{halfSel[15]}}, halfSel};
      LD_LHU:  data_o = {16'h0000, halfSel};
      LD_LW:   data_o = load_data_i;
      default: data_o = '0;
    endcase
  end

  // Halfword loads need an even address, word loads a word-aligned one;
  // only meaningful when the instruction actually writes back load data.
  always_comb begin
    misalign_o = 1'b0;
    if (is_load_i) begin
      if ((load_type_i == LD_LH || load_type_i == LD_LHU) && addr_lo_i[0])
        misalign_o = 1'b1;
      else if (load_type_i == LD_LW && addr_lo_i != 2'd0)
        misalign_o = 1'b1;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back pipeline stage: one stage register fed from MEM, drives the
// register-file write port, flags misaligned loads and counts retirements.
// Optional forwarding taps are built when WB_FWD_EN is defined.
module wb_stage import wb_pkg::*; (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [4:0]      in_rd,
  input  logic            in_rf_we,
  input  logic [1:0]      in_wb_sel,
  input  logic [XLEN-1:0] in_alu,
  input  logic [XLEN-1:0] in_pc4,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_load_data,
  input  logic [2:0]      in_load_type,
  input  logic [1:0]      in_addr_lo,
  input  logic            stall,
  input  logic            flush,
`ifdef WB_FWD_EN
  input  logic [4:0]      fwd_rs1,
  input  logic [4:0]      fwd_rs2,
`endif
  output logic [4:0]      w_addr,
  output logic            wen,
  output logic [XLEN-1:0] w_data,
  output logic            misalign_err,
`ifdef WB_FWD_EN
  output logic            fwd_rs1_hit,
  output logic            fwd_rs2_hit,
  output logic [XLEN-1:0] fwd_data,
`endif
  output logic [XLEN-1:0] retire_cnt
);

  stage_t          stage_q, stage_d;
  logic [XLEN-1:0] retire_cnt_q, retire_cnt_d;
  logic            active;
  logic            isLoad;
  logic            misalign;
  logic [XLEN-1:0] loadData;

  // An entry does its work (write + retire) only in its first valid cycle;
  // done blocks repeats while the stage is held by a stall.
  assign active = stage_q.valid & ~stage_q.done;
  assign isLoad = (stage_q.wb_sel == WB_LOAD);

  load_ext u_load_ext (
    .load_data_i (stage_q.load_data),
    .load_type_i (stage_q.load_type),
    .addr_lo_i   (stage_q.addr_lo),
    .is_load_i   (isLoad),
    .data_o      (loadData),
    .misalign_o  (misalign)
  );

  // Stage next state: flush beats stall, stall holds the fields but marks
  // a valid entry done once it has had its write cycle, else load from MEM.
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d.valid = 1'b0;
      stage_d.done  = 1'b0;
    end else if (stall) begin
      stage_d.done = stage_q.done | stage_q.valid;
    end else begin
      stage_d.valid     = in_valid;
      stage_d.done      = 1'b0;
      stage_d.rd        = in_rd;
      stage_d.rf_we     = in_rf_we;
      stage_d.wb_sel    = wb_sel_e'(in_wb_sel);
      stage_d.alu       = in_alu;
      stage_d.pc4       = in_pc4;
      stage_d.imm       = in_imm;
      stage_d.load_data = in_load_data;
      stage_d.load_type = in_load_type;
      stage_d.addr_lo   = in_addr_lo;
    end
  end

  // Retirement counter advances once per instruction, written or not,
  // and wraps naturally at the top of its range.
  always_comb begin
    retire_cnt_d = retire_cnt_q + XLEN'(active);
  end

  // State registers; reset wipes the stage (including a held entry) and the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q      <= '0;
      retire_cnt_q <= '0;
    end else begin
      stage_q      <= stage_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Write-back data mux over the registered operands.
  always_comb begin
    w_data = '0;
    case (stage_q.wb_sel)
      WB_ALU:  w_data = stage_q.alu;
      WB_LOAD: w_data = loadData;
      WB_PC4:  w_data = stage_q.pc4;
      WB_IMM:  w_data = stage_q.imm;
      default: w_data = '0;
    endcase
  end

  assign w_addr       = stage_q.rd;
  assign wen          = active & stage_q.rf_we & (stage_q.rd != 5'd0) & ~misalign;
  assign misalign_err = active & misalign;
  assign retire_cnt   = retire_cnt_q;

`ifdef WB_FWD_EN
  assign fwd_rs1_hit = wen & (stage_q.rd == fwd_rs1);
  assign fwd_rs2_hit = wen & (stage_q.rd == fwd_rs2);
  assign fwd_data    = w_data;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage. Expected register-file writes are queued
// as stimulus is issued; a monitor pops one entry per observed write.
// Forwarding checks are included when WB_FWD_EN is defined.
module tb_wb_stage;
  import wb_pkg::*;

  localparam logic [31:0] ALU_D = 32'h11111111;
  localparam logic [31:0] PC4_D = 32'h22222222;
  localparam logic [31:0] IMM_D = 32'h33333333;
  localparam logic [31:0] MEM_D = 32'h80FF7F01;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [4:0]  in_rd;
  logic        in_rf_we;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu, in_pc4, in_imm, in_load_data;
  logic [2:0]  in_load_type;
  logic [1:0]  in_addr_lo;
  logic        stall, flush;
  logic [4:0]  w_addr;
  logic        wen;
  logic [31:0] w_data;
  logic        misalign_err;
  logic [31:0] retire_cnt;
`ifdef WB_FWD_EN
  logic [4:0]  fwd_rs1, fwd_rs2;
  logic        fwd_rs1_hit, fwd_rs2_hit;
  logic [31:0] fwd_data;
`endif

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [2:0]  lt;
    logic [1:0]  alo;
    logic [31:0] exp;
  } vec_t;

  wr_t  expQ[$];
  vec_t tbl[15];
  int   checksTotal  = 0;
  int   checksPassed = 0;
  logic [31:0] expCnt;

  wb_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_rd        (in_rd),
    .in_rf_we     (in_rf_we),
    .in_wb_sel    (in_wb_sel),
    .in_alu       (in_alu),
    .in_pc4       (in_pc4),
    .in_imm       (in_imm),
    .in_load_data (in_load_data),
    .in_load_type (in_load_type),
    .in_addr_lo   (in_addr_lo),
    .stall        (stall),
    .flush        (flush),
`ifdef WB_FWD_EN
    .fwd_rs1      (fwd_rs1),
    .fwd_rs2      (fwd_rs2),
`endif
    .w_addr       (w_addr),
    .wen          (wen),
    .w_data       (w_data),
    .misalign_err (misalign_err),
`ifdef WB_FWD_EN
    .fwd_rs1_hit  (fwd_rs1_hit),
    .fwd_rs2_hit  (fwd_rs2_hit),
    .fwd_data     (fwd_data),
`endif
    .retire_cnt   (retire_cnt)
  );

  always #5 clk = ~clk;

  // One comparison: count it, report it if it disagrees.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Present one MEM-side beat at the falling edge; it is sampled at the next rising edge.
  task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic we, input logic [1:0] sel,
                               input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] imm,
                               input logic [2:0] lt, input logic [1:0] alo, input logic st, input logic fl);
    @(negedge clk);
    in_valid     = v;
    in_rd        = rd;
    in_rf_we     = we;
    in_wb_sel    = sel;
    in_alu       = alu;
    in_pc4       = pc4;
    in_imm       = imm;
    in_load_data = MEM_D;
    in_load_type = lt;
    in_addr_lo   = alo;
    stall        = st;
    flush        = fl;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      stall    = 1'b0;
      flush    = 1'b0;
    end
  endtask

  // Monitor: every observed write must match the oldest queued expectation.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      #1;
      if (wen === 1'b1) begin
        if (expQ.size() == 0) begin
          checksTotal++;
          $display("[TB] FAIL spurious_write: got write to x%0d data 0x%08h, expected no write", w_addr, w_data);
        end else begin
          e = expQ.pop_front();
          checkOutput("write_addr", {27'b0, w_addr}, {27'b0, e.addr});
          checkOutput("write_data", w_data, e.data);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    tbl = '{
      '{WB_LOAD, 5'd1,  1'b1, ALU_D, PC4_D, IMM_D, LD_LB,  2'd3, 32'hFFFFFF80},
      '{WB_LOAD, 5'd2,  1'b1, ALU_D, PC4_D, IMM_D, LD_LBU, 2'd3, 32'h00000080},
      '{WB_LOAD, 5'd3,  1'b1, ALU_D, PC4_D, IMM_D, LD_LH,  2'd2, 32'hFFFF80FF},
      '{WB_LOAD, 5'd4,  1'b1, ALU_D, PC4_D, IMM_D, LD_LHU, 2'd0, 32'h00007F01},
      '{WB_LOAD, 5'd5,  1'b1, ALU_D, PC4_D, IMM_D, LD_LW,  2'd0, 32'h80FF7F01},
      '{WB_LOAD, 5'd6,  1'b1, ALU_D, PC4_D, IMM_D, LD_LB,  2'd1, 32'h0000007F},
      '{WB_LOAD, 5'd7,  1'b1, ALU_D, PC4_D, IMM_D, LD_LH,  2'd0, 32'h00007F01},
      '{WB_LOAD, 5'd8,  1'b1, ALU_D, PC4_D, IMM_D, 3'b011, 2'd0, 32'h00000000},
      '{WB_PC4,  5'd9,  1'b1, ALU_D, 32'h00001004, IMM_D, LD_LW, 2'd0, 32'h00001004},
      '{WB_IMM,  5'd10, 1'b1, ALU_D, PC4_D, 32'hFFFFF800, LD_LW, 2'd0, 32'hFFFFF800},
      '{WB_ALU,  5'd11, 1'b1, 32'hDEADBEEF, PC4_D, IMM_D, LD_LW, 2'd2, 32'hDEADBEEF},
      '{WB_LOAD, 5'd12, 1'b1, ALU_D, PC4_D, IMM_D, LD_LBU, 2'd2, 32'h000000FF},
      '{WB_LOAD, 5'd13, 1'b1, ALU_D, PC4_D, IMM_D, LD_LB,  2'd2, 32'hFFFFFFFF},
      '{WB_ALU,  5'd14, 1'b0, ALU_D, PC4_D, IMM_D, LD_LW,  2'd0, 32'h00000000},
      '{WB_LOAD, 5'd15, 1'b1, ALU_D, PC4_D, IMM_D, LD_LHU, 2'd2, 32'h000080FF}
    };

    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_rf_we = 1'b0; in_wb_sel = '0;
    in_alu = '0; in_pc4 = '0; in_imm = '0; in_load_data = '0; in_load_type = '0;
    in_addr_lo = '0; stall = 1'b0; flush = 1'b0;
`ifdef WB_FWD_EN
    fwd_rs1 = 5'd7; fwd_rs2 = 5'd0;
`endif
    expCnt = 0;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2;
    checkOutput("reset_wen",      {31'b0, wen}, 32'd0);
    checkOutput("reset_w_addr",   {27'b0, w_addr}, 32'd0);
    checkOutput("reset_w_data",   w_data, 32'd0);
    checkOutput("reset_misalign", {31'b0, misalign_err}, 32'd0);
    checkOutput("reset_retire",   retire_cnt, 32'd0);

    // Simple ALU write, one cycle latency
    applyStimulus(1, 5'd5, 1, WB_ALU, 32'h12345678, PC4_D, IMM_D, LD_LW, 2'd0, 0, 0);
    expQ.push_back('{5'd5, 32'h12345678}); expCnt++;
    idle(1); #2;
    checkOutput("alu_wen", {31'b0, wen}, 32'd1);
    idle(1); #2;
    checkOutput("alu_retire", retire_cnt, 32'd1);

    // Back-to-back load extension / select table
    foreach (tbl[i]) begin
      applyStimulus(1, tbl[i].rd, tbl[i].we, tbl[i].sel, tbl[i].alu, tbl[i].pc4, tbl[i].imm,
                    tbl[i].lt, tbl[i].alo, 0, 0);
      if (tbl[i].we) expQ.push_back('{tbl[i].rd, tbl[i].exp});
      expCnt++;
    end
    idle(3); #2;
    checkOutput("table_retire", retire_cnt, expCnt);

    // Write to x0 is dropped but still retires
    applyStimulus(1, 5'd0, 1, WB_ALU, 32'hAAAA5555, PC4_D, IMM_D, LD_LW, 2'd0, 0, 0);
    expCnt++;
    idle(1); #2;
    checkOutput("x0_wen", {31'b0, wen}, 32'd0);
    idle(1); #2;
    checkOutput("x0_retire", retire_cnt, expCnt);

    // Misaligned LW held by a stall: error pulses once, never writes
    applyStimulus(1, 5'd4, 1, WB_LOAD, ALU_D, PC4_D, IMM_D, LD_LW, 2'd2, 0, 0);
    expCnt++;
    applyStimulus(0, 5'd0, 0, WB_ALU, ALU_D, PC4_D, IMM_D, LD_LW, 2'd0, 1, 0); #2;
    checkOutput("lw_mis_err_first", {31'b0, misalign_err}, 32'd1);
    checkOutput("lw_mis_wen", {31'b0, wen}, 32'd0);
    applyStimulus(0, 5'd0, 0, WB_ALU, ALU_D, PC4_D, IMM_D, LD_LW, 2'd0, 1, 0); #2;
    checkOutput("lw_mis_err_second", {31'b0, misalign_err}, 32'd0);
    idle(1);

    // Misaligned LH, no stall
    applyStimulus(1, 5'd16, 1, WB_LOAD, ALU_D, PC4_D, IMM_D, LD_LH, 2'd1, 0, 0);
    expCnt++;
    idle(1); #2;
    checkOutput("lh_mis_err", {31'b0, misalign_err}, 32'd1);
    idle(1); #2;
    checkOutput("lh_mis_err_after", {31'b0, misalign_err}, 32'd0);
    checkOutput("mis_retire", retire_cnt, expCnt);

    // Stall held three cycles: single write, single retirement, fields held
    applyStimulus(1, 5'd3, 1, WB_ALU, 32'h0BADF00D, PC4_D, IMM_D, LD_LW, 2'd0, 0, 0);
    expQ.push_back('{5'd3, 32'h0BADF00D}); expCnt++;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 5'd9, 1, WB_ALU, 32'h99999999, PC4_D, IMM_D, LD_LW, 2'd0, 1, 0); #2;
      checkOutput("stall_wen", {31'b0, wen}, (k == 0) ? 32'd1 : 32'd0);
      checkOutput("stall_hold_addr", {27'b0, w_addr}, 32'd3);
    end
    idle(2); #2;
    checkOutput("stall_retire", retire_cnt, expCnt);

    // Stall and flush together: the current write survives, stage empties
    applyStimulus(1, 5'd6, 1, WB_ALU, 32'h66666666, PC4_D, IMM_D, LD_LW, 2'd0, 0, 0);
    expQ.push_back('{5'd6, 32'h66666666}); expCnt++;
    applyStimulus(1, 5'd10, 1, WB_ALU, 32'hAAAA0000, PC4_D, IMM_D, LD_LW, 2'd0, 1, 1); #2;
    checkOutput("flush_keeps_write", {31'b0, wen}, 32'd1);
    idle(1); #2;
    checkOutput("flush_empty_wen", {31'b0, wen}, 32'd0);
    idle(1); #2;
    checkOutput("flush_retire", retire_cnt, expCnt);

    // Counter wrap
    idle(1);
    force dut.retire_cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.retire_cnt_q;
    #1;
    checkOutput("wrap_preset", retire_cnt, 32'hFFFFFFFF);
    applyStimulus(1, 5'd0, 1, WB_ALU, ALU_D, PC4_D, IMM_D, LD_LW, 2'd0, 0, 0);
    idle(2); #2;
    checkOutput("wrap_retire", retire_cnt, 32'd0);

    // Reset while a written entry is held by a stall
    applyStimulus(1, 5'd8, 1, WB_IMM, ALU_D, PC4_D, 32'h88888888, LD_LW, 2'd0, 0, 0);
    expQ.push_back('{5'd8, 32'h88888888});
    applyStimulus(0, 5'd0, 0, WB_ALU, ALU_D, PC4_D, IMM_D, LD_LW, 2'd0, 1, 0); #2;
    checkOutput("pre_rst_wen", {31'b0, wen}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;
    #2;
    checkOutput("rst_stall_wen",      {31'b0, wen}, 32'd0);
    checkOutput("rst_stall_w_addr",   {27'b0, w_addr}, 32'd0);
    checkOutput("rst_stall_w_data",   w_data, 32'd0);
    checkOutput("rst_stall_misalign", {31'b0, misalign_err}, 32'd0);
    checkOutput("rst_stall_retire",   retire_cnt, 32'd0);

`ifdef WB_FWD_EN
    // Forwarding taps follow the live write
    applyStimulus(1, 5'd7, 1, WB_ALU, 32'hC0DE0007, PC4_D, IMM_D, LD_LW, 2'd0, 0, 0);
    expQ.push_back('{5'd7, 32'hC0DE0007});
    idle(1); #2;
    checkOutput("fwd_rs1_hit", {31'b0, fwd_rs1_hit}, 32'd1);
    checkOutput("fwd_rs2_hit", {31'b0, fwd_rs2_hit}, 32'd0);
    checkOutput("fwd_data",    fwd_data, 32'hC0DE0007);
    idle(1); #2;
    checkOutput("fwd_rs1_idle", {31'b0, fwd_rs1_hit}, 32'd0);
`endif

    idle(3); #2;
    checkOutput("scoreboard_drained", expQ.size(), 32'd0);
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
